l1_dcache: RTL
==============

Name: l1_dcache

Overview:
- Direct-mapped, write-back, write-allocate L1 data cache for the LC-3b pipeline.
- Sits directly downstream of the MEM-stage stall unit. It consumes that unit's mem_read, mem_write, mem_address and line_offset, and returns mem_rdata and mem_resp.
- On a miss it writes back the victim line and fills the new line over a 128-bit line interface to the cache arbiter / physical memory.
- A hit completes in the same cycle the request is presented; a miss stalls the requester until the fill completes.

Parameters:
- NUM_SETS, 8, number of lines. Must be a power of two from 2 to 64. INDEX_W = log2(NUM_SETS); tag width = 12 - INDEX_W.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_read  in  1  load request from the stall unit.
- mem_write  in  1  store request from the stall unit.
- mem_address  in  12  line address, lc3b_wb_adr (byte address [15:4]).
- line_offset  in  4  byte offset within the 16-byte line. Word select = [3:1].
- mem_wdata  in  16  store data.
- mem_byte_enable  in  2  byte-lane enables for stores. [0] = low byte, [1] = high byte.
- mem_rdata  out  16  load data; valid when mem_resp=1.
- mem_resp  out  1  request complete.
- pmem_read  out  1  line fill request.
- pmem_write  out  1  line writeback request.
- pmem_address  out  12  line address for fill or writeback.
- pmem_wdata  out  128  victim line data.
- pmem_rdata  in  128  fill line data.
- pmem_resp  in  1  physical memory transfer complete.

Behaviour:
- Storage:
  - Per line: valid, dirty, tag (12-INDEX_W bits) and 128-bit data.
  - index = mem_address[INDEX_W-1:0]; tag = mem_address[11:INDEX_W].
  - On reset, valid and dirty clear for all lines. Data and tag contents are don't-care.
- Reset values and reset mid-operation:
  - mem_resp=0, mem_rdata=0, pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0. State = S_HIT.
  - Asserting reset during a miss aborts it immediately; pmem_read and pmem_write drop asynchronously.
- States: S_HIT, S_WRITEBACK, S_ALLOCATE.
- S_HIT:
  - Request active = mem_read|mem_write. Hit = valid[index] & tag match.
  - Active and hit: mem_resp=1 combinationally in the same cycle.
    - Read: mem_rdata = data word line_offset[3:1].
    - Write: at the clock edge, only the enabled bytes of word line_offset[3:1] are updated, and dirty[index] is set.
  - Active and miss:
    - mem_resp=0.
    - The request line address is latched into miss_addr.
    - Next state is S_WRITEBACK if valid[index] & dirty[index], else S_ALLOCATE.
  - No request: all outputs hold their reset values.
- S_WRITEBACK:
  - pmem_write=1. pmem_address = {stored tag, index}. pmem_wdata = victim line.
  - Held stable until pmem_resp=1, then go to S_ALLOCATE and clear dirty.
- S_ALLOCATE:
  - pmem_read=1, pmem_address = miss_addr.
  - On pmem_resp=1: write pmem_rdata to the line, set its tag, set valid, clear dirty, and go to S_HIT.
  - The original request then hits on the following cycle, giving a minimum miss latency of fill latency + 1 cycle.
- mem_resp is never asserted outside S_HIT. mem_rdata=0 whenever mem_resp=0.
- pmem_read and pmem_write are never asserted together.
- The requester holds mem_* stable while mem_resp=0. The cache uses miss_addr, not the live address, during S_WRITEBACK and S_ALLOCATE.
- If mem_read and mem_write are both asserted, the request is treated as a write.
- mem_byte_enable=2'b00 on a write: counts as a hit or miss normally, changes no data, but still sets dirty.
- pmem_resp asserted while in S_HIT is ignored.

Test Plan:
- Cold read: after reset, read mem_address=12'h040, line_offset=4'h2.
  - Required: mem_resp=0; pmem_read=1 with pmem_address=12'h040.
  - Memory returns pmem_rdata with word1=16'hBEEF. Next cycle: mem_resp=1, mem_rdata=16'hBEEF.
- Hit latency: repeat the same read.
  - Required: mem_resp=1 in the same cycle, no pmem activity.
- Byte store: write mem_wdata=16'h12AB, byte_enable=2'b01, offset 4'h2 to the resident line.
  - Required: immediate resp. A subsequent read returns 16'hBEAB. dirty=1.
- Dirty eviction (NUM_SETS=8): read 12'h048, same index 0, different tag.
  - Required: pmem_write=1, pmem_address=12'h040, pmem_wdata word1=16'hBEAB.
  - Then pmem_read=1, pmem_address=12'h048, then the hit completes.
- Clean eviction: a conflict miss on a clean line goes straight to S_ALLOCATE with no pmem_write.
- Reset mid-fill: assert reset while pmem_read=1.
  - Required: pmem_read=0 immediately. A later read to the same address misses again (valid was cleared).

Source files
------------

// File: rtl/l1_dcache.sv
// Direct-mapped, write-back, write-allocate L1 data cache with a 128-bit line interface.
// Hits respond combinationally; misses write back a dirty victim, then fill the line.
module l1_dcache #(
    parameter int unsigned NUM_SETS = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [11:0]  mem_address,
    input  logic [3:0]   line_offset,
    input  logic [15:0]  mem_wdata,
    input  logic [1:0]   mem_byte_enable,
    output logic [15:0]  mem_rdata,
    output logic         mem_resp,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [11:0]  pmem_address,
    output logic [127:0] pmem_wdata,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp
);
    localparam int unsigned INDEX_W = $clog2(NUM_SETS);
    localparam int unsigned TAG_W   = 12 - INDEX_W;

    typedef enum logic [1:0] {S_HIT, S_WRITEBACK, S_ALLOCATE} state_e;

    state_e              state_q, state_d;
    logic [NUM_SETS-1:0] valid_q, valid_d;
    logic [NUM_SETS-1:0] dirty_q, dirty_d;
    logic [11:0]         miss_addr_q, miss_addr_d;
    logic [TAG_W-1:0]    tag_q  [NUM_SETS];
    logic [127:0]        data_q [NUM_SETS];

    logic [INDEX_W-1:0]  req_idx, miss_idx;
    logic [TAG_W-1:0]    req_tag;
    logic [2:0]          word_sel;
    logic                active, hit;
    logic [127:0]        req_line, merged_line;
    logic                unused_byte_sel;

    // Byte address bit 0 never selects anything: accesses are word-granular.
    assign unused_byte_sel = line_offset[0];

    always_comb begin
        req_idx  = mem_address[INDEX_W-1:0];
        req_tag  = mem_address[11:INDEX_W];
        miss_idx = miss_addr_q[INDEX_W-1:0];
        word_sel = line_offset[3:1];
        active   = mem_read | mem_write;
        hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
        req_line = data_q[req_idx];
        merged_line = req_line;
        if (mem_byte_enable[0]) merged_line[{word_sel, 4'b0000} +: 8] = mem_wdata[7:0];
        if (mem_byte_enable[1]) merged_line[{word_sel, 4'b1000} +: 8] = mem_wdata[15:8];
    end

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        miss_addr_d = miss_addr_q;
        unique case (state_q)
            S_HIT: begin
                if (active) begin
                    if (hit) begin
                        if (mem_write) dirty_d[req_idx] = 1'b1;
                    end else begin
                        miss_addr_d = mem_address;
                        state_d = (valid_q[req_idx] && dirty_q[req_idx]) ? S_WRITEBACK : S_ALLOCATE;
                    end
                end
            end
            S_WRITEBACK: begin
                if (pmem_resp) begin
                    dirty_d[miss_idx] = 1'b0;
                    state_d = S_ALLOCATE;
                end
            end
            S_ALLOCATE: begin
                if (pmem_resp) begin
                    valid_d[miss_idx] = 1'b1;
                    dirty_d[miss_idx] = 1'b0;
                    state_d = S_HIT;
                end
            end
            default: state_d = S_HIT;
        endcase
    end

    always_comb begin
        mem_resp     = (state_q == S_HIT) && active && hit;
        mem_rdata    = (mem_resp && !mem_write) ? req_line[{word_sel, 4'b0000} +: 16] : '0;
        pmem_read    = (state_q == S_ALLOCATE);
        pmem_write   = (state_q == S_WRITEBACK);
        pmem_address = '0;
        pmem_wdata   = '0;
        if (state_q == S_WRITEBACK) begin
            pmem_address = {tag_q[miss_idx], miss_idx};
            pmem_wdata   = data_q[miss_idx];
        end else if (state_q == S_ALLOCATE) begin
            pmem_address = miss_addr_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_HIT;
            valid_q     <= '0;
            dirty_q     <= '0;
            miss_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
            miss_addr_q <= miss_addr_d;
        end
    end

    // Tag/data arrays need no reset; valid gates every use of them.
    always_ff @(posedge clk) begin
        if (state_q == S_HIT && active && hit && mem_write) begin
            data_q[req_idx] <= merged_line;
        end else if (state_q == S_ALLOCATE && pmem_resp) begin
            data_q[miss_idx] <= pmem_rdata;
            tag_q[miss_idx]  <= miss_addr_q[11:INDEX_W];
        end
    end
endmodule
